aes_round_sequencer: RTL and testbench

The round sequencer drives one AES-128 encryption through the four round-stage modules: AddRoundKey, SubBytes, ShiftRows and MixColumns. It holds the 128-bit working state and broadcasts it to the stages. It pulses each stage's synchronous clear, enables one stage at a time and captures that stage's result when it reports done. It also tells the key schedule which round key it needs and waits for that key to be valid.

---
 rtl/aes_round_sequencer.sv | 136 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: sequences one AES-128 encryption through the AddRoundKey/SubBytes/ShiftRows/MixColumns stages
// Ports:
//    clk, rst (async active-low)      clock and reset
//    start, data_in                   launch encryption of a plaintext block (accepted in IDLE/ERROR)
//    key_ready, round                 key schedule handshake: round-key index and its validity
//    busy, done, error, data_out      status and ciphertext result
//    stage_state, stage_clr           working state broadcast and synchronous clear to all stages
//    *_en / *_done / *_out            per-stage enable, sticky completion flag and result bus
module aes_round_sequencer #(
   parameter int word_size  = 8,
   parameter int array_size = 16,
   parameter int NR         = 10,
   parameter int TIMEOUT    = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [word_size*array_size-1:0]   data_in,
   input  logic                              key_ready,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   output logic [word_size*array_size-1:0]   data_out,
   output logic [3:0]                        round,
   output logic [word_size*array_size-1:0]   stage_state,
   output logic                              stage_clr,
   output logic                              ark_en,
   output logic                              sub_en,
   output logic                              shr_en,
   output logic                              mix_en,
   input  logic                              ark_done,
   input  logic                              sub_done,
   input  logic                              shr_done,
   input  logic                              mix_done,
   input  logic [word_size*array_size-1:0]   ark_out,
   input  logic [word_size*array_size-1:0]   sub_out,
   input  logic [word_size*array_size-1:0]   shr_out,
   input  logic [word_size*array_size-1:0]   mix_out
);
   localparam int W  = word_size * array_size;
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, CLR, RUN, DONE, ERROR} state_t;
   typedef enum logic [1:0] {ARK, SUB, SHR, MIX} stage_t;
   state_t         state;
   stage_t         stage;
   stage_t         next_stage;
   logic           run_en;
   logic [CW-1:0]  cnt;
   logic           cur_en;
   logic           cur_done;
   logic           last;
   logic [W-1:0]   cur_out;
   // AddRoundKey may only run while the key schedule presents a valid key
   assign ark_en = run_en && stage == ARK && key_ready;
   assign sub_en = run_en && stage == SUB;
   assign shr_en = run_en && stage == SHR;
   assign mix_en = run_en && stage == MIX;
   always_comb begin
      cur_en     = ark_en | sub_en | shr_en | mix_en;
      cur_done   = stage == ARK ? ark_done : stage == SUB ? sub_done : stage == SHR ? shr_done : mix_done;
      cur_out    = stage == ARK ? ark_out : stage == SUB ? sub_out : stage == SHR ? shr_out : mix_out;
      last       = stage == ARK && round == 4'(NR);
      // the final round skips MixColumns
      next_stage = stage == ARK ? SUB : stage == SUB ? SHR : stage == SHR ? (round == 4'(NR) ? ARK : MIX) : ARK;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         stage       <= ARK;
         run_en      <= 1'b0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         round       <= '0;
         stage_state <= '0;
         data_out    <= '0;
         stage_clr   <= 1'b1;
      end else begin
         case (state)
            IDLE, ERROR: begin
               if (start) begin
                  state       <= CLR;
                  stage       <= ARK;
                  round       <= '0;
                  stage_state <= data_in;
                  error       <= 1'b0;
                  busy        <= 1'b1;
                  stage_clr   <= 1'b1;
               end else if (state == IDLE) begin
                  stage_clr <= 1'b0;
               end
            end
            CLR: begin
               stage_clr <= 1'b0;
               cnt       <= '0;
               run_en    <= 1'b1;
               state     <= RUN;
            end
            RUN: begin
               if (cur_en && cur_done) begin
                  stage_state <= cur_out;
                  run_en      <= 1'b0;
                  stage       <= next_stage;
                  if (stage == ARK && !last)
                     round <= round + 4'd1;
                  if (last) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     busy     <= 1'b0;
                     data_out <= cur_out;
                  end else begin
                     state     <= CLR;
                     stage_clr <= 1'b1;
                  end
               end else if (cur_en) begin
                  if (cnt == CW'(TIMEOUT - 1)) begin
                     state     <= ERROR;
                     error     <= 1'b1;
                     busy      <= 1'b0;
                     stage_clr <= 1'b1;
                     run_en    <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: checks the AES round sequencer against a behavioural AES-128 model
module tb_aes_round_sequencer;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         key_ready = 1'b1;
   logic [127:0] data_in = '0;
   logic         busy, done, error, stage_clr;
   logic [127:0] data_out, stage_state;
   logic [3:0]   round;
   logic         ark_en, sub_en, shr_en, mix_en;
   logic         ark_done = 1'b0, sub_done = 1'b0, shr_done = 1'b0, mix_done = 1'b0;
   logic [127:0] ark_out = '0, sub_out = '0, shr_out = '0, mix_out = '0;
   logic [127:0] rk [16];
   logic         mix_kill = 1'b0;
   int           n_chk = 0;
   int           n_fail = 0;

   aes_round_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .key_ready(key_ready),
      .busy(busy), .done(done), .error(error), .data_out(data_out), .round(round),
      .stage_state(stage_state), .stage_clr(stage_clr),
      .ark_en(ark_en), .sub_en(sub_en), .shr_en(shr_en), .mix_en(mix_en),
      .ark_done(ark_done), .sub_done(sub_done), .shr_done(shr_done), .mix_done(mix_done),
      .ark_out(ark_out), .sub_out(sub_out), .shr_out(shr_out), .mix_out(mix_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = xt(a);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse (x^254) then the affine map
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p, r, s, t;
      p = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      s = r ^ 8'h63;
      for (int n = 1; n < 5; n++) begin
         t = (r << n) | (r >> (8 - n));
         s ^= t;
      end
      return s;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
         o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
      return o;
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
      logic [127:0] s;
      s = pt ^ round_key(k, 0);
      for (int r = 1; r <= 10; r++) begin
         s = shift_rows(sub_bytes(s));
         if (r < 10) s = mix_cols(s);
         s ^= round_key(k, r);
      end
      return s;
   endfunction

   // Behavioural stages: done one cycle after enable, sticky until stage_clr
   always @(posedge clk) begin
      if (stage_clr) begin
         ark_done <= 1'b0;
         sub_done <= 1'b0;
         shr_done <= 1'b0;
         mix_done <= 1'b0;
      end else begin
         if (ark_en) begin ark_done <= 1'b1; ark_out <= stage_state ^ rk[round]; end
         if (sub_en) begin sub_done <= 1'b1; sub_out <= sub_bytes(stage_state); end
         if (shr_en) begin shr_done <= 1'b1; shr_out <= shift_rows(stage_state); end
         if (mix_en && !mix_kill) begin mix_done <= 1'b1; mix_out <= mix_cols(stage_state); end
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load_key(input logic [127:0] k);
      for (int r = 0; r < 11; r++) rk[r] = round_key(k, r);
   endtask

   task automatic reset_checks(input string nm);
      chk({nm, " busy"}, busy, 0);
      chk({nm, " done"}, done, 0);
      chk({nm, " error"}, error, 0);
      chk({nm, " enables"}, {ark_en, sub_en, shr_en, mix_en}, 0);
      chk({nm, " round"}, round, 0);
      chk({nm, " stage_state"}, stage_state, 0);
      chk({nm, " data_out"}, data_out, 0);
      chk({nm, " stage_clr"}, stage_clr, 1);
   endtask

   task automatic run_block(input string nm, input logic [127:0] pt, input logic [127:0] k,
                            input bit stall, input bit spur, input int exp_cyc, input logic [127:0] exp_ct);
      int dc = 0, busy_bad = 0, en_cyc = 0, multi = 0, mix10 = 0, clr_n = 0, rsteps = 0, rbad = 0, err_n = 0, ark_stall = 0;
      int nen;
      logic [127:0] dout = '0;
      logic [3:0] pr;
      load_key(k);
      @(negedge clk);
      data_in = pt;
      key_ready = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      pr = 4'd0;
      for (int cyc = 1; cyc <= exp_cyc + 40 && dc == 0; cyc++) begin
         @(negedge clk);
         start = spur && (cyc == 10 || cyc == 121);
         key_ready = !(stall && cyc >= 38 && cyc <= 44);
         #1;
         if (busy !== (cyc < exp_cyc)) busy_bad++;
         nen = int'(ark_en) + int'(sub_en) + int'(shr_en) + int'(mix_en);
         if (nen > 1) multi++;
         if (nen != 0) en_cyc++;
         if (mix_en && round == 4'd10) mix10++;
         if (stage_clr) clr_n++;
         if (round !== pr) begin
            if (round !== pr + 4'd1) rbad++;
            rsteps++;
            pr = round;
         end
         if (error) err_n++;
         if (stall && cyc >= 38 && cyc <= 44 && ark_en) ark_stall++;
         if (done) begin
            dc = cyc;
            dout = data_out;
         end
      end
      chk({nm, " done_cycle"}, dc, exp_cyc);
      chk({nm, " ciphertext"}, dout, exp_ct);
      chk({nm, " busy_window_errors"}, busy_bad, 0);
      chk({nm, " multi_enable_cycles"}, multi, 0);
      chk({nm, " enable_cycles"}, en_cyc, 80);
      chk({nm, " mix_in_round10"}, mix10, 0);
      chk({nm, " stage_clr_cycles"}, clr_n, 40);
      chk({nm, " round_steps"}, rsteps, 10);
      chk({nm, " round_step_errors"}, rbad, 0);
      chk({nm, " error_cycles"}, err_n, 0);
      if (stall) chk({nm, " ark_en_during_stall"}, ark_stall, 0);
      @(negedge clk);
      start = 1'b0;
      key_ready = 1'b1;
      #1;
      chk({nm, " done_pulse_len"}, done, 0);
      chk({nm, " busy_after_done"}, busy, 0);
      chk({nm, " data_out_hold"}, data_out, exp_ct);
   endtask

   typedef struct {
      logic [127:0] pt;
      logic [127:0] key;
      bit           stall;
      bit           spur;
      int           cyc;
      bit           fixed;
      logic [127:0] ct;
   } vec_t;

   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   initial begin
      vec_t tbl [7];
      logic [127:0] prev;
      int mcyc, ecyc;
      tbl[0] = '{FIPS_PT, FIPS_KEY, 1'b0, 1'b0, 121, 1'b1, FIPS_CT};
      tbl[1] = '{FIPS_PT, FIPS_KEY, 1'b1, 1'b0, 128, 1'b1, FIPS_CT};
      tbl[2] = '{FIPS_PT, FIPS_KEY, 1'b0, 1'b1, 121, 1'b1, FIPS_CT};
      for (int i = 3; i < 7; i++)
         tbl[i] = '{{$urandom(), $urandom(), $urandom(), $urandom()},
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    i == 6, 1'b0, i == 6 ? 128 : 121, 1'b0, '0};

      repeat (3) @(negedge clk);
      #1 reset_checks("por");
      @(negedge clk);
      rst = 1'b1;
      #1 chk("por clr_first_cycle", stage_clr, 1);
      @(posedge clk);
      #1 chk("por clr_released", stage_clr, 0);

      for (int i = 0; i < 7; i++)
         run_block($sformatf("vec%0d", i), tbl[i].pt, tbl[i].key, tbl[i].stall, tbl[i].spur,
                   tbl[i].cyc, tbl[i].fixed ? tbl[i].ct : aes_ref(tbl[i].pt, tbl[i].key));

      // MixColumns never completes: timeout must fire after TIMEOUT enabled cycles
      mix_kill = 1'b1;
      load_key(FIPS_KEY);
      prev = aes_ref(tbl[6].pt, tbl[6].key);
      @(negedge clk);
      data_in = FIPS_PT;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      mcyc = 0;
      ecyc = 0;
      for (int cyc = 1; cyc <= 400 && ecyc == 0; cyc++) begin
         @(negedge clk);
         #1;
         if (error) ecyc = cyc;
         else if (mix_en) mcyc++;
      end
      chk("tout mix_en_cycles", mcyc, 255);
      chk("tout error_cycle", ecyc, 266);
      chk("tout error", error, 1);
      chk("tout busy", busy, 0);
      chk("tout stage_clr", stage_clr, 1);
      chk("tout enables", {ark_en, sub_en, shr_en, mix_en}, 0);
      chk("tout data_out", data_out, prev);
      @(negedge clk);
      #1 chk("tout error_sticky", error, 1);
      mix_kill = 1'b0;
      run_block("after_tout", FIPS_PT, FIPS_KEY, 1'b0, 1'b0, 121, FIPS_CT);

      // asynchronous reset in the middle of a block
      @(negedge clk);
      data_in = FIPS_PT;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (50) @(negedge clk);
      #1 chk("mid busy_before", busy, 1);
      rst = 1'b0;
      #1 reset_checks("midrst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1 chk("midrst clr_first_cycle", stage_clr, 1);
      @(posedge clk);
      #1 chk("midrst clr_released", stage_clr, 0);
      chk("midrst busy_idle", busy, 0);
      run_block("after_rst", FIPS_PT, FIPS_KEY, 1'b0, 1'b0, 121, FIPS_CT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end
endmodule
